// File: rtl/mem_stage.sv
// Memory-access stage of the SPU pipeline: forwards ALU results and runs quadword
// loads/stores against the local store over a req/ack handshake with timeout.
module mem_stage #(
    parameter int unsigned LS_ADDR_W = 14,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         alu_result,
    input  logic [127:0]         store_data,
    input  logic [6:0]           dest_reg,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    input  logic                 flush,
    output logic                 ls_req,
    output logic                 ls_we,
    output logic [LS_ADDR_W-1:0] ls_addr,
    output logic [127:0]         ls_wdata,
    input  logic                 ls_ack,
    input  logic [127:0]         ls_rdata,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [6:0]           wb_dest_reg,
    output logic [127:0]         wb_data,
    output logic                 err
);

    localparam int unsigned DATA_W = 128;
    localparam int unsigned REG_W  = 7;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 flushed_q, flushed_d;
    logic [REG_W-1:0]     dest_q, dest_d;
    logic                 rw_q, rw_d;

    logic                 ls_req_d, ls_we_d;
    logic [LS_ADDR_W-1:0] ls_addr_d;
    logic [DATA_W-1:0]    ls_wdata_d;
    logic                 wb_valid_d, wb_reg_write_d;
    logic [REG_W-1:0]     wb_dest_reg_d;
    logic [DATA_W-1:0]    wb_data_d;
    logic                 err_d;

    assign in_ready = (state_q == IDLE);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flushed_q    <= 1'b0;
            dest_q       <= '0;
            rw_q         <= 1'b0;
            ls_req       <= 1'b0;
            ls_we        <= 1'b0;
            ls_addr      <= '0;
            ls_wdata     <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_dest_reg  <= '0;
            wb_data      <= '0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flushed_q    <= flushed_d;
            dest_q       <= dest_d;
            rw_q         <= rw_d;
            ls_req       <= ls_req_d;
            ls_we        <= ls_we_d;
            ls_addr      <= ls_addr_d;
            ls_wdata     <= ls_wdata_d;
            wb_valid     <= wb_valid_d;
            wb_reg_write <= wb_reg_write_d;
            wb_dest_reg  <= wb_dest_reg_d;
            wb_data      <= wb_data_d;
            err          <= err_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        flushed_d      = flushed_q;
        dest_d         = dest_q;
        rw_d           = rw_q;
        ls_req_d       = ls_req;
        ls_we_d        = ls_we;
        ls_addr_d      = ls_addr;
        ls_wdata_d     = ls_wdata;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_dest_reg_d  = wb_dest_reg;
        wb_data_d      = wb_data;
        err_d          = err;

        unique case (state_q)
            IDLE: begin
                // A flushed bundle is consumed but produces nothing
                if (in_valid && !flush) begin
                    if (mem_read || mem_write) begin
                        state_d    = ACCESS;
                        cnt_d      = '0;
                        flushed_d  = 1'b0;
                        dest_d     = dest_reg;
                        rw_d       = reg_write;
                        ls_req_d   = 1'b1;
                        ls_we_d    = mem_write;
                        ls_addr_d  = alu_result[LS_ADDR_W+3:4];
                        ls_wdata_d = store_data;
                        if (mem_read && mem_write) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = reg_write;
                        wb_dest_reg_d  = dest_reg;
                        wb_data_d      = alu_result;
                    end
                end
            end
            ACCESS: begin
                flushed_d = flushed_q || flush;
                if (ls_ack) begin
                    state_d       = IDLE;
                    ls_req_d      = 1'b0;
                    wb_valid_d    = !(flushed_q || flush);
                    wb_dest_reg_d = dest_q;
                    if (ls_we) begin
                        wb_reg_write_d = 1'b0;
                        wb_data_d      = '0;
                    end else begin
                        wb_reg_write_d = rw_q;
                        wb_data_d      = ls_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abort: report the failed access without a register write
                    state_d        = IDLE;
                    ls_req_d       = 1'b0;
                    err_d          = 1'b1;
                    wb_valid_d     = !(flushed_q || flush);
                    wb_reg_write_d = 1'b0;
                    wb_dest_reg_d  = dest_q;
                    wb_data_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each bundle's outcome is predicted from the
// transaction (op kind, ack delay, flush point) and checked cycle by cycle.
module tb_mem_stage;

    localparam int unsigned LS_ADDR_W = 14;
    localparam int unsigned TMO       = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [127:0]         alu_result;
    logic [127:0]         store_data;
    logic [6:0]           dest_reg;
    logic                 mem_read, mem_write, reg_write, flush;
    logic                 ls_req, ls_we;
    logic [LS_ADDR_W-1:0] ls_addr;
    logic [127:0]         ls_wdata;
    logic                 ls_ack;
    logic [127:0]         ls_rdata;
    logic                 wb_valid, wb_reg_write;
    logic [6:0]           wb_dest_reg;
    logic [127:0]         wb_data;
    logic                 err;

    int n_checks = 0;
    int n_pass   = 0;
    logic exp_err = 1'b0;

    mem_stage #(.LS_ADDR_W(LS_ADDR_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .dest_reg(dest_reg),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .flush(flush),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_dest_reg(wb_dest_reg), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Non-memory bundle; fl discards it
    task automatic alu_op(input logic [127:0] a, input logic [6:0] d, input logic rw, input logic fl);
        check("alu_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1; alu_result = a; dest_reg = d; reg_write = rw;
        mem_read = 1'b0; mem_write = 1'b0; flush = fl;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("alu_wb_valid", 128'(wb_valid), 128'(!fl));
        if (!fl) begin
            check("alu_wb_data", wb_data, a);
            check("alu_wb_dest", 128'(wb_dest_reg), 128'(d));
            check("alu_wb_rw", 128'(wb_reg_write), 128'(rw));
        end
        check("alu_ls_req", 128'(ls_req), 128'(0));
    endtask

    // Memory bundle; k = request cycle carrying the ack (k > TMO: never acked).
    // fl: 0 none, 1 flush on accept, j >= 2 flush in request cycle j-1.
    task automatic mem_op(input logic [127:0] a, input logic [127:0] sd, input logic [6:0] d,
                          input logic rd, input logic wr, input logic rw,
                          input int k, input int fl, input logic [127:0] rdat);
        int  nreq;
        logic timed_out;
        logic [127:0] exp_addr;
        nreq      = (k > int'(TMO)) ? int'(TMO) : k;
        timed_out = (k > int'(TMO));
        exp_addr  = 128'(a[LS_ADDR_W+3:4]);
        check("mem_ready", 128'(in_ready), 128'(1));
        in_valid = 1'b1; alu_result = a; store_data = sd; dest_reg = d;
        mem_read = rd; mem_write = wr; reg_write = rw; flush = (fl == 1);
        step();
        in_valid = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        if (fl == 1) begin
            check("disc_wb_valid", 128'(wb_valid), 128'(0));
            check("disc_ls_req", 128'(ls_req), 128'(0));
            check("disc_ready", 128'(in_ready), 128'(1));
            return;
        end
        if (rd && wr) exp_err = 1'b1;
        for (int i = 1; i <= nreq; i++) begin
            check("req_high", 128'(ls_req), 128'(1));
            check("req_not_ready", 128'(in_ready), 128'(0));
            check("req_we", 128'(ls_we), 128'(wr));
            check("req_addr", 128'(ls_addr), exp_addr);
            if (wr) check("req_wdata", ls_wdata, sd);
            check("req_no_wb", 128'(wb_valid), 128'(0));
            ls_ack = (i == k); ls_rdata = (i == k) ? rdat : rand128();
            flush = (fl == i + 1);
            step();
            ls_ack = 1'b0; flush = 1'b0;
        end
        if (timed_out) exp_err = 1'b1;
        check("done_req_low", 128'(ls_req), 128'(0));
        check("done_ready", 128'(in_ready), 128'(1));
        check("done_wb_valid", 128'(wb_valid), 128'(fl == 0));
        if (fl == 0) begin
            check("done_wb_rw", 128'(wb_reg_write), 128'(!timed_out && !wr && rw));
            check("done_wb_data", wb_data, (timed_out || wr) ? 128'(0) : rdat);
            check("done_wb_dest", 128'(wb_dest_reg), 128'(d));
        end
        check("done_err", 128'(err), 128'(exp_err));
        if (timed_out) begin
            ls_ack = 1'b1; ls_rdata = rand128();
            step();
            ls_ack = 1'b0;
            check("stray_ack_wb", 128'(wb_valid), 128'(0));
            check("stray_ack_req", 128'(ls_req), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] a;
        reset_n = 1'b0; in_valid = 1'b0; alu_result = '0; store_data = '0; dest_reg = '0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; flush = 1'b0;
        ls_ack = 1'b0; ls_rdata = '0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        check("rst_ready", 128'(in_ready), 128'(1));
        check("rst_req", 128'(ls_req), 128'(0));
        check("rst_we", 128'(ls_we), 128'(0));
        check("rst_addr", 128'(ls_addr), 128'(0));
        check("rst_wdata", ls_wdata, 128'(0));
        check("rst_wb_valid", 128'(wb_valid), 128'(0));
        check("rst_wb_data", wb_data, 128'(0));
        check("rst_wb_dest", 128'(wb_dest_reg), 128'(0));
        check("rst_err", 128'(err), 128'(0));
        step();

        alu_op(128'h1234, 7'd5, 1'b1, 1'b0);
        alu_op(rand128(), 7'd10, 1'b1, 1'b0);
        alu_op(rand128(), 7'd11, 1'b0, 1'b0);
        alu_op(rand128(), 7'd12, 1'b1, 1'b0);
        step();
        check("idle_no_wb", 128'(wb_valid), 128'(0));

        mem_op(128'h0001_2345, rand128(), 7'd3, 1'b1, 1'b0, 1'b1, 3, 0,
               {4{32'hDEAD_BEEF}});
        mem_op(rand128(), rand128(), 7'd4, 1'b0, 1'b1, 1'b1, 1, 0, rand128());
        mem_op(rand128(), rand128(), 7'd6, 1'b1, 1'b0, 1'b1, 5, 0, rand128());
        mem_op(rand128(), rand128(), 7'd7, 1'b1, 1'b0, 1'b1, 3, 2, rand128());
        mem_op(rand128(), rand128(), 7'd8, 1'b1, 1'b1, 1'b1, 2, 0, rand128());

        // Reset in the middle of an access
        in_valid = 1'b1; alu_result = rand128(); mem_read = 1'b1; flush = 1'b0;
        step();
        in_valid = 1'b0; mem_read = 1'b0;
        check("mid_req", 128'(ls_req), 128'(1));
        #2 reset_n = 1'b0;
        #1;
        exp_err = 1'b0;
        check("async_req_drop", 128'(ls_req), 128'(0));
        check("async_ready", 128'(in_ready), 128'(1));
        check("async_err_clr", 128'(err), 128'(0));
        @(posedge clk);
        #3 reset_n = 1'b1;
        ls_ack = 1'b1;
        step();
        ls_ack = 1'b0;
        check("post_rst_wb", 128'(wb_valid), 128'(0));
        check("post_rst_req", 128'(ls_req), 128'(0));
        check("post_rst_ready", 128'(in_ready), 128'(1));

        for (int n = 0; n < 300; n++) begin
            int kind, k, fl;
            logic rd, wr;
            kind = int'($urandom_range(0, 15));
            a = rand128();
            if (kind < 6) begin
                alu_op(a, 7'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
            end else begin
                rd = (kind < 11) || (kind == 15);
                wr = (kind >= 11);
                k  = int'($urandom_range(1, TMO + 1));
                fl = 0;
                if ($urandom_range(0, 5) == 0)
                    fl = int'($urandom_range(1, ((k > int'(TMO)) ? TMO : k) + 1));
                if (rd && wr && fl == 1) fl = 0;
                mem_op(a, rand128(), 7'($urandom), rd, wr, 1'($urandom), k, fl, rand128());
            end
            if ($urandom_range(0, 3) == 0) begin
                step();
                check("gap_no_wb", 128'(wb_valid), 128'(0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the SPU pipeline, directly downstream of the execute stage. It accepts the execute-stage bundle (ALU result, store data, destination register, control bits) and performs quadword loads/stores to the local store over a req/ack handshake. While an access is outstanding it stalls upstream. It presents a registered writeback bundle to the writeback stage.

## Interface
- LS_ADDR_W, 14: local-store quadword index width (256 KB / 16 B).
- TIMEOUT, 64: maximum cycles to wait for `ls_ack` before aborting an access.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- alu_result  in  128  address for memory ops; data for non-memory ops.
- store_data  in  128  ReadData2 pass-through, used as store data.
- dest_reg  in  7  destination register (RT/RRR already selected upstream).
- mem_read, mem_write, reg_write  in  1 each  control bits.
- flush  in  1  discard any bundle not yet written back.
- ls_req  out  1  local-store request.
- ls_we  out  1  1 = store, 0 = load.
- ls_addr  out  LS_ADDR_W  equals `alu_result[LS_ADDR_W+3:4]`.
- ls_wdata  out  128  store data.
- ls_ack  in  1  local-store completion; `ls_rdata` is valid in the same cycle.
- ls_rdata  in  128  load data.
- wb_valid  out  1  writeback bundle valid for one cycle.
- wb_reg_write  out  1  register-file write enable.
- wb_dest_reg  out  7  destination register.
- wb_data  out  128  write data.
- err  out  1  sticky: timeout or illegal control seen.

## Operation
- States: IDLE, ACCESS.
- `in_ready` = 1 in IDLE, 0 in ACCESS.
- An input is accepted when `in_valid && in_ready` at a clock edge.
- Non-memory op (`mem_read` = `mem_write` = 0), accepted in IDLE:
  - Next cycle: `wb_valid` = 1, `wb_data` = `alu_result`, `wb_reg_write` = `reg_write`, `wb_dest_reg` = `dest_reg`.
  - State stays IDLE.
- Memory op, accepted in IDLE:
  - Latch address, store data, dest and control.
  - Go to ACCESS. `ls_req` = 1 from the next cycle until the cycle `ls_ack` is seen (inclusive).
  - `ls_we`, `ls_addr` and `ls_wdata` are held stable while `ls_req` = 1.
- `ls_ack` in ACCESS:
  - Next cycle: state = IDLE and `wb_valid` = 1.
  - Load: `wb_data` = `ls_rdata` (registered at ack), `wb_reg_write` = latched `reg_write`.
  - Store: `wb_reg_write` = 0, `wb_data` = 0.
- Address bits [3:0] are ignored (quadword aligned). Bits above LS_ADDR_W+3 are ignored (wrap).
- `mem_read && mem_write`: executed as a store, and `err` is set.
- Timeout: a cycle counter runs in ACCESS and clears on entry.
  - When it reaches TIMEOUT-1 without `ls_ack`: drop `ls_req`, return to IDLE, set `err`, emit `wb_valid` = 1 with `wb_reg_write` = 0.
  - A late `ls_ack` arriving while in IDLE is ignored.
- Flush:
  - In IDLE: the registered `wb_valid` on the next cycle is forced to 0, and a bundle accepted in the same cycle is discarded.
  - In ACCESS: the handshake runs to completion (`ls_req` is not retracted; a store still commits). The resulting `wb_valid` is suppressed.
- `err` clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, counter = 0.
  - `ls_req`, `ls_we`, `wb_valid`, `wb_reg_write`, `err` = 0.
  - `ls_addr`, `ls_wdata`, `wb_dest_reg`, `wb_data` = 0.
  - `in_ready` = 1 immediately after reset deasserts.
- Reset asserted mid-access drops `ls_req` at once. No writeback is emitted.
- Latency, non-memory op: 1 cycle from accept to `wb_valid`.
- Latency, memory op: accept at edge N; `ls_req` high from cycle N+1; ack at cycle N+k; `wb_valid` at N+k+1. Minimum 2 cycles (ack in the first request cycle).
- Back-to-back:
  - A new bundle can be accepted in the cycle `wb_valid` is high, because IDLE has already been re-entered.
  - Throughput: 1 per cycle for non-memory ops; 1 per (k+1) cycles for memory ops.
- `wb_valid` is a one-cycle pulse. All outputs are registered except `in_ready`, which decodes state.

## Test plan
- Reset then ALU op: `alu_result` = 0x…1234, `dest_reg` = 5, `reg_write` = 1 -> next cycle `wb_valid` = 1, `wb_data` = 0x…1234, `wb_dest_reg` = 5. Also drive three back-to-back ops -> 3 consecutive `wb_valid` cycles.
- Load with ack delay 3: `alu_result` = 0x0001_2345, `mem_read` -> `ls_addr` = 0x1234, `ls_req` high for 3 cycles, `in_ready` = 0 throughout; `ls_rdata` = 0xDEAD… -> `wb_data` = 0xDEAD…, `wb_reg_write` = 1 one cycle after ack.
- Store with immediate ack: `ls_we` = 1, `ls_wdata` = `store_data`; `wb_valid` = 1 with `wb_reg_write` = 0, 2 cycles after accept.
- Timeout with TIMEOUT = 4 and no ack -> `ls_req` drops after 4 cycles, `err` = 1, `wb_reg_write` = 0. A later stray `ls_ack` produces no `wb_valid`.
- Flush during a load access -> `ls_req` held until ack, no `wb_valid`. `mem_read` = `mem_write` = 1 -> store performed, `err` = 1.
- `reset_n` low during ACCESS -> `ls_req` = 0 asynchronously; after release `in_ready` = 1 and no stale writeback appears.
